data_mem_dumper: RTL and testbench
==================================

// Module: data_mem_dumper
// PURPOSE
//  Debug-side reader of the data memory written by the MEM stage. When the pipeline is halted and
//  i_start pulses, walks data-memory words 0..N_WORDS-1 through a dedicated read port and streams
//  each word out LSB-byte-first on a valid/ready byte interface toward the debug UART TX.
// PARAMETERS
//  NB_DATA  32   data-memory word width; multiple of 8
//  NB_ADDR  8    data-memory address width; <= 8 when DATA_MEM_DIRTY_ONLY_EN is defined
//  N_WORDS  256  words dumped per request; 1..2**NB_ADDR
// PORTS
//  clk            in   1        single clock
//  i_reset        in   1        synchronous, active-high reset
//  i_halt         in   1        pipeline halted; dump may run only while high
//  i_start        in   1        dump request pulse
//  o_rd_addr      out  NB_ADDR  data-memory read address
//  i_rd_data      in   NB_DATA  read data; valid the cycle after o_rd_addr changes
//  i_mem_write    in   1        MEM-stage store strobe (used only with the macro)
//  i_mem_addr     in   NB_ADDR  MEM-stage store address (used only with the macro)
//  o_tx_data      out  8        byte to transmitter
//  o_tx_valid     out  1        o_tx_data valid
//  i_tx_ready     in   1        transmitter accepts byte
//  o_busy         out  1        dump in progress
//  o_done         out  1        one-cycle pulse after the last byte is accepted
// BEHAVIOUR
//  - Reset: FSM=IDLE, o_rd_addr=0, o_tx_data=0, o_tx_valid=0, o_busy=0, o_done=0, byte idx=0.
//  - Reset has priority over all inputs, including mid-dump; it aborts immediately, no o_done.
//  - IDLE: i_start && i_halt -> RD_ADDR, o_busy=1 from the next cycle. i_start is ignored while
//    busy or while i_halt=0.
//  - RD_ADDR: o_rd_addr=word index; 1 cycle -> RD_WAIT.
//  - RD_WAIT: capture i_rd_data into word reg; byte idx=0 -> SEND.
//  - SEND: o_tx_valid=1, o_tx_data=word[8*idx+:8]. A byte transfers on the cycle valid&&ready.
//    Data and valid hold stable until transfer. After byte NB_DATA/8-1: if word index = N_WORDS-1
//    -> DONE, else index+1 -> RD_ADDR.
//  - DONE: o_done=1 for 1 cycle, o_busy=0 -> IDLE.
//  - Per word: 2 overhead cycles + 1 cycle per byte at ready=1.
//    Default config: first byte valid on cycle 3 after start.
//  - i_halt falling mid-dump: abort next cycle to IDLE. o_tx_valid drops, no o_done, index=0.
//  - Index counter is NB_ADDR+1 bits wide; no wrap when N_WORDS = 2**NB_ADDR.
// CONFIGURATION
//  DATA_MEM_DIRTY_ONLY_EN defined:
//  - a 2**NB_ADDR dirty bitmap is set on i_mem_write at i_mem_addr and cleared only by reset.
//  - the dump skips clean words (skipping costs 1 cycle per word, no bytes sent).
//  - each dirty word is preceded by a tag byte = zero-extended address (SEND_TAG state).
//  - a store on the same cycle as the scan of that address counts as dirty.
//  - with zero dirty words, o_done still pulses.
//  Undefined: bitmap absent, i_mem_write/i_mem_addr ignored, all N_WORDS dumped, no tag bytes.
// STRUCTURE
//  - Package dump_pkg: FSM state localparams (IDLE, RD_ADDR, RD_WAIT, SEND_TAG, SEND, DONE),
//    BYTES_PER_WORD = NB_DATA/8.
//  - Sub-module dump_dirty_tracker (bitmap + lookup), instantiated only under the macro.
// TESTING
//  1 mem[0]=0x11223344, mem[1]=0xA5A5A5A5, N_WORDS=2, ready=1, halt=1, start
//    -> bytes 44 33 22 11 A5 A5 A5 A5, then o_done pulse, o_busy low.
//  2 Same, ready toggles 1/0 every cycle -> identical byte sequence; data stable while ready=0.
//  3 Start with halt=0; start while busy -> no effect, no extra bytes, exactly one o_done.
//  4 Reset asserted after the 3rd byte of a dump -> all outputs 0 next cycle.
//    A new start then sends 44 first again.
//  5 Halt drops mid-word -> o_tx_valid=0 next cycle, no o_done, next dump restarts at address 0.
//  6 Macro on: stores to addr 0x05 (0xDEADBEEF) and 0x80 (0x1) -> 05 EF BE AD DE 80 01 00 00 00,
//    then o_done. Macro on, no stores -> o_done only.

Source files
------------

// File: rtl/dump_pkg.sv
// Shared types for the data-memory dumper: FSM state encoding and word/byte sizing helpers.
package dump_pkg;

  localparam int DEFAULT_NB_DATA = 32;
  localparam int BYTES_PER_WORD  = DEFAULT_NB_DATA / 8;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_WAIT,
    SEND_TAG,
    SEND,
    DONE
  } state_e;

  function automatic int bytes_per_word(input int nb_data);
    return nb_data / 8;
  endfunction

endpackage

// File: rtl/dump_dirty_tracker.sv
// Dirty bitmap over the whole data-memory address space; a bit is set by every MEM-stage store.
// The lookup also reports a store landing on the looked-up address in the same cycle.
module dump_dirty_tracker
  import dump_pkg::*;
#(
  parameter int NB_ADDR = 8
) (
  input  logic               clk,
  input  logic               i_reset,
  input  logic               i_mem_write,
  input  logic [NB_ADDR-1:0] i_mem_addr,
  input  logic [NB_ADDR-1:0] i_lookup_addr,
  output logic               o_dirty
);

  localparam int N_ENTRIES = 2 ** NB_ADDR;

  logic [N_ENTRIES-1:0] dirty;

  always_ff @(posedge clk) begin
    // NOTE: unlike a RAM array, this bitmap is reset, because reset is the only way it clears.
    if (i_reset) begin
      dirty <= '0;
    end else if (i_mem_write) begin
      dirty[i_mem_addr] <= 1'b1;
    end
  end

  assign o_dirty = dirty[i_lookup_addr] | (i_mem_write && (i_mem_addr == i_lookup_addr));

endmodule

// File: rtl/data_mem_dumper.sv
// Walks data memory while the pipeline is halted and streams each word LSB-byte-first to the UART.
// Define DATA_MEM_DIRTY_ONLY_EN to dump only stored-to words, each preceded by its address byte.
module data_mem_dumper
  import dump_pkg::*;
#(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 8,
  parameter int N_WORDS = 256
) (
  input  logic               clk,
  input  logic               i_reset,
  input  logic               i_halt,
  input  logic               i_start,
  output logic [NB_ADDR-1:0] o_rd_addr,
  input  logic [NB_DATA-1:0] i_rd_data,
  input  logic               i_mem_write,
  input  logic [NB_ADDR-1:0] i_mem_addr,
  output logic [7:0]         o_tx_data,
  output logic               o_tx_valid,
  input  logic               i_tx_ready,
  output logic               o_busy,
  output logic               o_done
);

  localparam int BPW     = bytes_per_word(NB_DATA);
  localparam int NB_BIDX = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [NB_ADDR:0]   LAST_IDX  = (NB_ADDR + 1)'(N_WORDS - 1);
  localparam logic [NB_BIDX-1:0] LAST_BYTE = NB_BIDX'(BPW - 1);

  state_e               state, state_nxt;
  logic [NB_ADDR:0]     idx, idx_nxt;
  logic [NB_BIDX-1:0]   byte_idx, byte_idx_nxt;
  logic [NB_DATA-1:0]   word, word_nxt;
  logic                 word_dirty;
  logic                 running;

`ifdef DATA_MEM_DIRTY_ONLY_EN
  localparam bit TAG_EN = 1'b1;

  dump_dirty_tracker #(
    .NB_ADDR (NB_ADDR)
  ) u_dirty_tracker (
    .clk           (clk),
    .i_reset       (i_reset),
    .i_mem_write   (i_mem_write),
    .i_mem_addr    (i_mem_addr),
    .i_lookup_addr (o_rd_addr),
    .o_dirty       (word_dirty)
  );
`else
  localparam bit TAG_EN = 1'b0;
  logic unused_mem_port;

  assign word_dirty      = 1'b1;
  assign unused_mem_port = ^{i_mem_write, i_mem_addr};
`endif

  assign running = state inside {RD_ADDR, RD_WAIT, SEND_TAG, SEND};

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    if (i_reset) begin
      state    <= IDLE;
      idx      <= '0;
      byte_idx <= '0;
      word     <= '0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      byte_idx <= byte_idx_nxt;
      word     <= word_nxt;
    end
  end

  always_comb begin
    // NOTE: defaults first so no path through the case leaves a signal unassigned (no latch).
    state_nxt    = state;
    idx_nxt      = idx;
    byte_idx_nxt = byte_idx;
    word_nxt     = word;

    unique case (state)
      IDLE: begin
        if (i_start && i_halt) begin
          state_nxt = RD_ADDR;
          idx_nxt   = '0;
        end
      end
      RD_ADDR: begin
        if (word_dirty) begin
          state_nxt = RD_WAIT;
        end else if (idx == LAST_IDX) begin
          state_nxt = DONE;
        end else begin
          idx_nxt = idx + 1'b1;
        end
      end
      RD_WAIT: begin
        word_nxt     = i_rd_data;
        byte_idx_nxt = '0;
        state_nxt    = TAG_EN ? SEND_TAG : SEND;
      end
      SEND_TAG: begin
        if (i_tx_ready) state_nxt = SEND;
      end
      SEND: begin
        if (i_tx_ready) begin
          if (byte_idx == LAST_BYTE) begin
            byte_idx_nxt = '0;
            if (idx == LAST_IDX) begin
              state_nxt = DONE;
            end else begin
              idx_nxt   = idx + 1'b1;
              state_nxt = RD_ADDR;
            end
          end else begin
            byte_idx_nxt = byte_idx + 1'b1;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
        idx_nxt   = '0;
      end
      default: state_nxt = IDLE;
    endcase

    // Losing halt mid-dump abandons the walk; the next request starts over at word 0.
    if (running && !i_halt) begin
      state_nxt    = IDLE;
      idx_nxt      = '0;
      byte_idx_nxt = '0;
    end
  end

  assign o_rd_addr  = idx[NB_ADDR-1:0];
  assign o_busy     = running;
  assign o_tx_valid = state inside {SEND_TAG, SEND};
  assign o_done     = (state == DONE);

  always_comb begin
    o_tx_data = '0;
    if (state == SEND_TAG) begin
      o_tx_data = 8'(o_rd_addr);
    end else if (state == SEND) begin
      o_tx_data = word[8*byte_idx +: 8];
    end
  end

endmodule

// File: tb/tb_data_mem_dumper.sv
// Directed bench for data_mem_dumper; the dirty-only scenario runs when DATA_MEM_DIRTY_ONLY_EN is set.
module tb_data_mem_dumper;

`ifdef DATA_MEM_DIRTY_ONLY_EN
  localparam int TB_N_WORDS = 256;
`else
  localparam int TB_N_WORDS = 2;
`endif

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_halt = 1'b1;
  logic        i_start = 1'b0;
  logic [7:0]  rd_addr;
  logic [31:0] rd_data = '0;
  logic        i_mem_write = 1'b0;
  logic [7:0]  i_mem_addr = '0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        busy;
  logic        done;

  logic [31:0] mem [256];
  logic [7:0]  got[$];
  int          done_cnt = 0;
  int          checks = 0;
  int          failures = 0;
  bit          chk_stable = 1'b0;
  bit          prev_hold = 1'b0;
  logic [7:0]  prev_data = '0;

  logic [7:0] exp_a[$] = '{8'h44, 8'h33, 8'h22, 8'h11, 8'hA5, 8'hA5, 8'hA5, 8'hA5};
  logic [7:0] exp_d[$] = '{8'h05, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h80, 8'h01, 8'h00, 8'h00, 8'h00};
  logic [7:0] exp_none[$];

  data_mem_dumper #(
    .NB_DATA (32),
    .NB_ADDR (8),
    .N_WORDS (TB_N_WORDS)
  ) dut (
    .clk         (clk),
    .i_reset     (i_reset),
    .i_halt      (i_halt),
    .i_start     (i_start),
    .o_rd_addr   (rd_addr),
    .i_rd_data   (rd_data),
    .i_mem_write (i_mem_write),
    .i_mem_addr  (i_mem_addr),
    .o_tx_data   (tx_data),
    .o_tx_valid  (tx_valid),
    .i_tx_ready  (tx_ready),
    .o_busy      (busy),
    .o_done      (done)
  );

  always #5 clk = ~clk;

  // Synchronous-read data memory: data follows the address by one cycle.
  always @(posedge clk) rd_data <= mem[rd_addr];

  task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    checks++;
    if (got_v !== exp_v) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got_v, exp_v);
    end
  endtask

  // Byte monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (chk_stable && prev_hold)
      check("hold_stable", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, prev_data});
    if (tx_valid && tx_ready) got.push_back(tx_data);
    if (done) done_cnt++;
    prev_hold = tx_valid && !tx_ready;
    prev_data = tx_data;
  end

  task automatic pulse_start();
    @(posedge clk); #1 i_start = 1'b1;
    @(posedge clk); #1 i_start = 1'b0;
  endtask

  task automatic wait_done(input int max_cycles, input bit toggle,
                           output bit seen, output logic busy_at_done);
    seen = 1'b0;
    busy_at_done = 1'bx;
    for (int n = 0; n < max_cycles && !seen; n++) begin
      @(posedge clk); #1;
      if (toggle) tx_ready = ~tx_ready;
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        busy_at_done = busy;
      end
    end
  endtask

  task automatic check_bytes(input string tag, input logic [7:0] exp[$]);
    check({tag, "_count"}, 32'(got.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      check($sformatf("%s_b%0d", tag, i), 32'(got[i]), 32'(exp[i]));
  endtask

  task automatic wait_bytes(input int n, input int max_cycles);
    for (int c = 0; c < max_cycles && got.size() < n; c++) begin
      @(negedge clk); #1;
    end
  endtask

  initial begin
    bit   seen;
    logic bz;
    int   d0;

    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[0] = 32'h1122_3344;
    mem[1] = 32'hA5A5_A5A5;

    repeat (3) @(posedge clk);
    #1 i_reset = 1'b0;
    @(negedge clk);
    check("rst_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_busy",  {31'd0, busy},     32'd0);
    check("rst_done",  {31'd0, done},     32'd0);
    check("rst_addr",  {24'd0, rd_addr},  32'd0);
    check("rst_data",  {24'd0, tx_data},  32'd0);

`ifndef DATA_MEM_DIRTY_ONLY_EN
    // 1: two words at full rate, first byte on cycle 3.
    got.delete();
    d0 = done_cnt;
    pulse_start();
    @(negedge clk);
    check("t1_c1_busy",  {31'd0, busy},     32'd1);
    check("t1_c1_valid", {31'd0, tx_valid}, 32'd0);
    @(negedge clk);
    check("t1_c2_valid", {31'd0, tx_valid}, 32'd0);
    @(negedge clk);
    check("t1_c3_valid", {31'd0, tx_valid}, 32'd1);
    check("t1_c3_data",  {24'd0, tx_data},  32'h44);
    wait_done(60, 1'b0, seen, bz);
    check("t1_done", {31'd0, seen}, 32'd1);
    check("t1_busy_at_done", {31'd0, bz}, 32'd0);
    @(negedge clk); #1;
    check_bytes("t1", exp_a);
    check("t1_done_cnt", done_cnt - d0, 1);

    // 2: ready toggles every cycle.
    got.delete();
    chk_stable = 1'b1;
    pulse_start();
    wait_done(100, 1'b1, seen, bz);
    chk_stable = 1'b0;
    tx_ready = 1'b1;
    check("t2_done", {31'd0, seen}, 32'd1);
    @(negedge clk); #1;
    check_bytes("t2", exp_a);

    // 3: start without halt is ignored; a second start while busy is ignored.
    got.delete();
    d0 = done_cnt;
    i_halt = 1'b0;
    pulse_start();
    repeat (10) @(negedge clk);
    #1;
    check("t3_nohalt_busy",  {31'd0, busy}, 32'd0);
    check("t3_nohalt_bytes", 32'(got.size()), 32'd0);
    check("t3_nohalt_done",  done_cnt - d0, 0);
    i_halt = 1'b1;
    pulse_start();
    pulse_start();
    wait_done(60, 1'b0, seen, bz);
    check("t3_done", {31'd0, seen}, 32'd1);
    repeat (20) @(negedge clk);
    #1;
    check_bytes("t3", exp_a);
    check("t3_done_cnt", done_cnt - d0, 1);

    // 4: reset after the third byte.
    got.delete();
    d0 = done_cnt;
    pulse_start();
    wait_bytes(3, 60);
    check("t4_reached3", 32'(got.size()), 32'd3);
    @(posedge clk); #1 i_reset = 1'b1;
    @(posedge clk); #1 i_reset = 1'b0;
    @(negedge clk);
    check("t4_valid", {31'd0, tx_valid}, 32'd0);
    check("t4_busy",  {31'd0, busy},     32'd0);
    check("t4_done",  {31'd0, done},     32'd0);
    check("t4_data",  {24'd0, tx_data},  32'd0);
    check("t4_addr",  {24'd0, rd_addr},  32'd0);
    repeat (10) @(negedge clk);
    #1;
    check("t4_no_done", done_cnt - d0, 0);
    got.delete();
    pulse_start();
    wait_done(60, 1'b0, seen, bz);
    @(negedge clk); #1;
    check_bytes("t4_restart", exp_a);

    // 5: halt drops in the middle of word 1.
    got.delete();
    d0 = done_cnt;
    pulse_start();
    wait_bytes(6, 60);
    check("t5_reached6", 32'(got.size()), 32'd6);
    @(posedge clk); #1 i_halt = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("t5_valid", {31'd0, tx_valid}, 32'd0);
    check("t5_busy",  {31'd0, busy},     32'd0);
    repeat (10) @(negedge clk);
    #1;
    check("t5_no_done", done_cnt - d0, 0);
    i_halt = 1'b1;
    got.delete();
    pulse_start();
    @(negedge clk);
    check("t5_restart_addr", {24'd0, rd_addr}, 32'd0);
    wait_done(60, 1'b0, seen, bz);
    @(negedge clk); #1;
    check_bytes("t5_restart", exp_a);
`else
    // 6a: nothing stored -> done only.
    got.delete();
    d0 = done_cnt;
    pulse_start();
    wait_done(1000, 1'b0, seen, bz);
    check("t6a_done", {31'd0, seen}, 32'd1);
    check("t6a_busy_at_done", {31'd0, bz}, 32'd0);
    @(negedge clk); #1;
    check_bytes("t6a", exp_none);
    check("t6a_done_cnt", done_cnt - d0, 1);

    // 6b: two stores -> tagged words only.
    @(posedge clk); #1;
    i_mem_write = 1'b1; i_mem_addr = 8'h05; mem[8'h05] = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    i_mem_addr = 8'h80; mem[8'h80] = 32'h0000_0001;
    @(posedge clk); #1;
    i_mem_write = 1'b0;
    got.delete();
    d0 = done_cnt;
    pulse_start();
    wait_done(1000, 1'b0, seen, bz);
    check("t6b_done", {31'd0, seen}, 32'd1);
    @(negedge clk); #1;
    check_bytes("t6b", exp_d);
    check("t6b_done_cnt", done_cnt - d0, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
